// File: rtl/elastic_buffer_pkg.sv
// Shared constants and helpers for the elastic buffer.
// Bypass-mode encodings and the occupancy-counter width.
package elastic_buffer_pkg;

   localparam int BUF_REGISTERED = 0;
   localparam int BUF_BYPASS     = 1;

   function automatic int clog2_cnt(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// Entry storage for the elastic buffer.
// One gated write port, one asynchronous read port, no reset.
module elastic_buffer_mem
   import elastic_buffer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer.sv
// Parametrised ready/valid elastic buffer with optional empty bypass.
// ready_o decodes registered occupancy only, breaking the backpressure path.
module elastic_buffer
   import elastic_buffer_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 2,
   parameter int BYPASS       = BUF_REGISTERED,
   parameter int AFULL_THRESH = DEPTH - 1,
   localparam int CNT_W       = clog2_cnt(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              almost_full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF   = CNT_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   generate
      if (DEPTH < 2) begin : g_bad_depth
         $error("elastic_buffer: DEPTH must be >= 2");
      end
      if (DATA_W < 1) begin : g_bad_width
         $error("elastic_buffer: DATA_W must be >= 1");
      end
      if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_af
         $error("elastic_buffer: AFULL_THRESH out of 1..DEPTH");
      end
   endgenerate

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic              afull;
   logic [DATA_W-1:0] rd_data;
   logic              bypass_path;
   logic              push;
   logic              pop;
   logic              store;
   logic              advance;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      bypass_path = (BYPASS == BUF_BYPASS) && (count == '0);
      ready_o     = (count != FULL);
      valid_o     = bypass_path ? valid_i : (count != '0);
      data_o      = bypass_path ? data_i : rd_data;
      push        = valid_i & ready_o;
      pop         = valid_o & ready_i;
      // a bypassed beat consumed downstream is never written
      store       = push & ~(bypass_path & pop);
      advance     = pop & ~bypass_path;
      count_nxt   = count;
      if (flush_i) begin
         count_nxt = '0;
      end else if (store & ~advance) begin
         count_nxt = count + CNT_W'(1);
      end else if (advance & ~store) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         afull  <= 1'b0;
      end else begin
         count <= count_nxt;
         afull <= (count_nxt >= AF);
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (store) begin
               wr_ptr <= inc(wr_ptr);
            end
            if (advance) begin
               rd_ptr <= inc(rd_ptr);
            end
         end
      end
   end

   elastic_buffer_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (store & ~flush_i),
      .waddr (wr_ptr),
      .wdata (data_i),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign count_o       = count;
   assign almost_full_o = afull;

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer with per-instance scoreboards.
// Instances: depth 4 registered, depth 3 registered, depth 4 bypass.
module tb_elastic_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       fl0 = 1'b0, vi0 = 1'b0, ri0 = 1'b0, ro0, vo0, af0;
   logic [7:0] di0 = '0, do0;
   logic [2:0] cnt0;
   logic       fl1 = 1'b0, vi1 = 1'b0, ri1 = 1'b0, ro1, vo1, af1;
   logic [7:0] di1 = '0, do1;
   logic [1:0] cnt1;
   logic       fl2 = 1'b0, vi2 = 1'b0, ri2 = 1'b0, ro2, vo2, af2;
   logic [7:0] di2 = '0, do2;
   logic [2:0] cnt2;

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [7:0] q2 [$];

   int passed = 0;
   int total  = 0;
   int sent;
   logic acc;

   always #5 clk = ~clk;

   elastic_buffer #(.DATA_W(8), .DEPTH(4), .BYPASS(0)) u0 (
      .clk(clk), .rst(rst), .flush_i(fl0), .valid_i(vi0), .ready_o(ro0),
      .data_i(di0), .valid_o(vo0), .ready_i(ri0), .data_o(do0),
      .count_o(cnt0), .almost_full_o(af0));

   elastic_buffer #(.DATA_W(8), .DEPTH(3), .BYPASS(0)) u1 (
      .clk(clk), .rst(rst), .flush_i(fl1), .valid_i(vi1), .ready_o(ro1),
      .data_i(di1), .valid_o(vo1), .ready_i(ri1), .data_o(do1),
      .count_o(cnt1), .almost_full_o(af1));

   elastic_buffer #(.DATA_W(8), .DEPTH(4), .BYPASS(1)) u2 (
      .clk(clk), .rst(rst), .flush_i(fl2), .valid_i(vi2), .ready_o(ro2),
      .data_i(di2), .valid_o(vo2), .ready_i(ri2), .data_o(do2),
      .count_o(cnt2), .almost_full_o(af2));

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic sb(input int k, input logic vi, input logic ro,
                     input logic vo, input logic ri, input logic fl,
                     input logic [7:0] di, input logic [7:0] dox);
      logic [7:0] e;
      int n;
      e = '0;
      if (vi && ro) begin
         case (k)
            0: q0.push_back(di);
            1: q1.push_back(di);
            default: q2.push_back(di);
         endcase
      end
      if (vo && ri) begin
         n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
         check($sformatf("sb%0d_expected_beat", k), 32'(n != 0), 32'd1);
         if (n != 0) begin
            case (k)
               0: e = q0.pop_front();
               1: e = q1.pop_front();
               default: e = q2.pop_front();
            endcase
            check($sformatf("sb%0d_data", k), 32'(dox), 32'(e));
         end
      end
      if (fl) begin
         case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sb(0, vi0, ro0, vo0, ri0, fl0, di0, do0);
      sb(1, vi1, ro1, vo1, ri1, fl1, di1, do1);
      sb(2, vi2, ro2, vo2, ri2, fl2, di2, do2);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid0", 32'(vo0), 0);
      check("rst_count0", 32'(cnt0), 0);
      check("rst_af0", 32'(af0), 0);
      rst = 1'b0;
      #1;
      check("rst_ready0", 32'(ro0), 1);
      check("rst_ready1", 32'(ro1), 1);
      check("rst_count1", 32'(cnt1), 0);

      // 1: pass-through latency with ready_i high
      ri0 = 1'b1;
      vi0 = 1'b1; di0 = 8'hA1;
      #1;
      check("t1_valid_c0", 32'(vo0), 0);
      tick();
      di0 = 8'hA2;
      #1;
      check("t1_data_c1", 32'(do0), 32'hA1);
      check("t1_count_c1", 32'(cnt0), 1);
      tick();
      di0 = 8'hA3;
      #1;
      check("t1_data_c2", 32'(do0), 32'hA2);
      check("t1_count_c2", 32'(cnt0), 1);
      tick();
      vi0 = 1'b0;
      #1;
      check("t1_data_c3", 32'(do0), 32'hA3);
      check("t1_count_c3", 32'(cnt0), 1);
      tick();
      check("t1_drained", 32'(vo0), 0);

      // 2: fill to full, then release backpressure
      ri0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vi0 = 1'b1; di0 = 8'(i);
         #1;
         check($sformatf("t2_ready_%0d", i), 32'(ro0), 32'(i < 4));
         check($sformatf("t2_count_%0d", i), 32'(cnt0),
               32'((i < 4) ? i : 4));
         check($sformatf("t2_af_%0d", i), 32'(af0), 32'(i >= 3));
         tick();
      end
      ri0 = 1'b1;
      #1;
      check("t2_full_ready_same", 32'(ro0), 0);
      check("t2_head", 32'(do0), 0);
      tick();
      check("t2_ready_next", 32'(ro0), 1);
      check("t2_count_next", 32'(cnt0), 3);
      tick();
      vi0 = 1'b0;
      repeat (5) tick();
      check("t2_empty", 32'(cnt0), 0);
      check("t2_sb_empty", 32'(q0.size()), 0);

      // 3: depth 3 wrap with random backpressure
      sent = 0;
      for (int c = 0; c < 300 && (sent < 20 || q1.size() != 0); c++) begin
         vi1 = (sent < 20);
         di1 = 8'h30 + 8'(sent);
         ri1 = 1'($urandom_range(0, 1));
         #1;
         acc = vi1 && ro1;
         tick();
         if (acc) sent++;
      end
      vi1 = 1'b0;
      check("t3_sent", 32'(sent), 20);
      check("t3_sb_empty", 32'(q1.size()), 0);
      check("t3_count", 32'(cnt1), 0);

      // 4: bypass when empty
      ri2 = 1'b1; vi2 = 1'b1; di2 = 8'h55;
      #1;
      check("t4_valid_same", 32'(vo2), 1);
      check("t4_data_same", 32'(do2), 32'h55);
      tick();
      check("t4_count_pass", 32'(cnt2), 0);
      ri2 = 1'b0;
      #1;
      check("t4_data_stall", 32'(do2), 32'h55);
      tick();
      vi2 = 1'b0;
      #1;
      check("t4_count_held", 32'(cnt2), 1);
      check("t4_data_held", 32'(do2), 32'h55);
      ri2 = 1'b1;
      tick();
      check("t4_count_done", 32'(cnt2), 0);

      // 5: flush with a concurrent push
      ri0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vi0 = 1'b1; di0 = 8'h10 + 8'(i);
         tick();
      end
      vi0 = 1'b1; di0 = 8'h77; fl0 = 1'b1;
      #1;
      check("t5_count_pre", 32'(cnt0), 3);
      tick();
      vi0 = 1'b0; fl0 = 1'b0;
      #1;
      check("t5_count_post", 32'(cnt0), 0);
      check("t5_valid_post", 32'(vo0), 0);
      ri0 = 1'b1;
      repeat (3) tick();

      // 6: asynchronous reset mid-cycle
      ri0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vi0 = 1'b1; di0 = 8'h20 + 8'(i);
         tick();
      end
      vi0 = 1'b0;
      #1;
      check("t6_count_pre", 32'(cnt0), 2);
      #1;
      rst = 1'b1;
      #1;
      check("t6_valid_rst", 32'(vo0), 0);
      check("t6_count_rst", 32'(cnt0), 0);
      q0.delete(); q1.delete(); q2.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      ri0 = 1'b1; vi0 = 1'b1; di0 = 8'h99;
      tick();
      vi0 = 1'b0;
      #1;
      check("t6_first_valid", 32'(vo0), 1);
      check("t6_first_data", 32'(do0), 32'h99);
      tick();
      check("t6_sb_empty", 32'(q0.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
